// File: rtl/calc_btn_ctrl.sv
// ---------------------------------------------------------------------------
// calc_btn_ctrl
//   Input controller in front of the calculator accumulator datapath.
//   Synchronises and debounces the raw accumulate button, issues exactly one
//   single-cycle accumulate strobe per accepted press, and captures the op
//   code and operand on the cycle the press is accepted. This keeps glitches,
//   bounce and mid-press input changes away from the datapath.
//
// Ports
//   clk       in   1      system clock, all state on rising edge
//   btnu      in   1      reset, asynchronous, active-high
//   btnd      in   1      raw accumulate button (asynchronous, may bounce)
//   btnl      in   1      raw op select bit 2
//   btnc      in   1      raw op select bit 1
//   btnr      in   1      raw op select bit 0
//   sw        in   16     raw operand switches
//   acc_en    out  1      one-cycle accumulate strobe
//   alu_op    out  4      captured op code {1'b0, btnl, btnc, btnr}
//   operand   out  16     captured switch value
//   busy      out  1      high whenever the FSM is not idle
//   press_cnt out  CNT_W  accepted press count, wraps silently
// ---------------------------------------------------------------------------
module calc_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             btnu,
  input  logic             btnd,
  input  logic             btnl,
  input  logic             btnc,
  input  logic             btnr,
  input  logic [15:0]      sw,
  output logic             acc_en,
  output logic [3:0]       alu_op,
  output logic [15:0]      operand,
  output logic             busy,
  output logic [CNT_W-1:0] press_cnt
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_FIRE     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [DB_W-1:0]  cnt_r;
  logic [DB_W-1:0]  cnt_s;
  logic             capture_s;
  logic             sync1_r;
  logic             sync2_r;
  logic             acc_en_r;
  logic             busy_r;
  logic [3:0]       alu_op_r;
  logic [15:0]      operand_r;
  logic [CNT_W-1:0] press_cnt_r;

  // Two-flop synchroniser for the asynchronous accumulate button.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btnd;
      sync2_r <= sync1_r;
    end
  end

  // Next-state and debounce-counter logic; capture_s marks the entry into FIRE.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sync2_r) begin
          state_s = ST_DEBOUNCE;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (!sync2_r) begin
          // Too short to be a press: drop it without a strobe.
          state_s = ST_IDLE;
        end else if (cnt_r == DB_LAST) begin
          state_s   = ST_FIRE;
          capture_s = 1'b1;
        end else begin
          cnt_s = cnt_r + DB_W'(1'b1);
        end
      end
      ST_FIRE: begin
        state_s = ST_RELEASE;
        cnt_s   = '0;
      end
      ST_RELEASE: begin
        if (!sync2_r) begin
          if (cnt_r == DB_LAST) begin
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_r + DB_W'(1'b1);
          end
        end else begin
          // Still held or bouncing: restart the release window.
          cnt_s = '0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counter and registered status outputs (strobe/busy follow next state).
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      acc_en_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      acc_en_r <= (state_s == ST_FIRE);
      busy_r   <= (state_s != ST_IDLE);
    end
  end

  // Op code and operand are sampled only on the edge that enters FIRE.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      alu_op_r  <= 4'd0;
      operand_r <= 16'd0;
    end else if (capture_s) begin
      alu_op_r  <= {1'b0, btnl, btnc, btnr};
      operand_r <= sw;
    end else begin
      alu_op_r  <= alu_op_r;
      operand_r <= operand_r;
    end
  end

  // Accepted-press counter, advanced once per FIRE cycle, wraps silently.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      press_cnt_r <= '0;
    end else if (state_r == ST_FIRE) begin
      press_cnt_r <= press_cnt_r + CNT_W'(1'b1);
    end else begin
      press_cnt_r <= press_cnt_r;
    end
  end

  assign acc_en    = acc_en_r;
  assign busy      = busy_r;
  assign alu_op    = alu_op_r;
  assign operand   = operand_r;
  assign press_cnt = press_cnt_r;

endmodule

// File: tb/tb_calc_btn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_btn_ctrl
//   Directed bench for calc_btn_ctrl with DEBOUNCE_CYCLES=4, CNT_W=8.
//   Inputs are driven 1 time unit after each rising edge and outputs are
//   sampled at the same point; acc_en pulses are counted on falling edges.
// ---------------------------------------------------------------------------
module tb_calc_btn_ctrl;

  logic        clk;
  logic        btnu;
  logic        btnd;
  logic        btnl;
  logic        btnc;
  logic        btnr;
  logic [15:0] sw;
  logic        acc_en;
  logic [3:0]  alu_op;
  logic [15:0] operand;
  logic        busy;
  logic [7:0]  press_cnt;

  int n_tests;
  int n_fail;
  int pulse_cnt;
  int p0;
  logic busy_seen;

  calc_btn_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .btnu(btnu),
    .btnd(btnd),
    .btnl(btnl),
    .btnc(btnc),
    .btnr(btnr),
    .sw(sw),
    .acc_en(acc_en),
    .alu_op(alu_op),
    .operand(operand),
    .busy(busy),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (acc_en) pulse_cnt = pulse_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    pulse_cnt = 0;
    btnu = 1'b0; btnd = 1'b0; btnl = 1'b0; btnc = 1'b0; btnr = 1'b0; sw = 16'h0000;
    #1 btnu = 1'b1;
    #1;
    check_eq("rst_acc_en",    32'(acc_en),    32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_alu_op",    32'(alu_op),    32'd0);
    check_eq("rst_operand",   32'(operand),   32'd0);
    check_eq("rst_press_cnt", 32'(press_cnt), 32'd0);
    tick(); tick();
    btnu = 1'b0;

    // T2: clean press, FIRE entered at edge 7.
    btnl = 1'b0; btnc = 1'b1; btnr = 1'b1; sw = 16'h1234;
    btnd = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) check_eq("t2_busy_e2", 32'(busy), 32'd0);
      if (k == 3) check_eq("t2_busy_e3", 32'(busy), 32'd1);
      if (k == 6) check_eq("t2_acc_e6",  32'(acc_en), 32'd0);
      if (k == 7) begin
        check_eq("t2_acc_e7",     32'(acc_en),    32'd1);
        check_eq("t2_alu_op",     32'(alu_op),    32'h3);
        check_eq("t2_operand",    32'(operand),   32'h1234);
        check_eq("t2_cnt_e7",     32'(press_cnt), 32'd0);
      end
      if (k == 8) begin
        check_eq("t2_acc_e8",     32'(acc_en),    32'd0);
        check_eq("t2_cnt_e8",     32'(press_cnt), 32'd1);
      end
    end
    btnd = 1'b0;
    repeat (5) tick();
    check_eq("t2_busy_rel5", 32'(busy), 32'd1);
    tick();
    check_eq("t2_busy_rel6", 32'(busy), 32'd0);
    check_eq("t2_pulses",    32'(pulse_cnt), 32'd1);

    // T1: async reset in the middle of DEBOUNCE.
    btnd = 1'b1;
    repeat (4) tick();
    check_eq("t1_busy_pre", 32'(busy), 32'd1);
    #2 btnu = 1'b1;
    #1;
    check_eq("t1_acc_en",    32'(acc_en),    32'd0);
    check_eq("t1_busy",      32'(busy),      32'd0);
    check_eq("t1_alu_op",    32'(alu_op),    32'd0);
    check_eq("t1_operand",   32'(operand),   32'd0);
    check_eq("t1_press_cnt", 32'(press_cnt), 32'd0);
    tick();
    btnu = 1'b0;
    // Button still held at release: treated as a fresh press.
    p0 = pulse_cnt;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) check_eq("t1_held_acc_e6", 32'(acc_en), 32'd0);
      if (k == 7) check_eq("t1_held_acc_e7", 32'(acc_en), 32'd1);
      if (k == 8) check_eq("t1_held_cnt",    32'(press_cnt), 32'd1);
    end
    btnd = 1'b0;
    repeat (10) tick();
    check_eq("t1_held_pulses", 32'(pulse_cnt - p0), 32'd1);

    // T3: two-cycle glitch is rejected.
    p0 = pulse_cnt;
    busy_seen = 1'b0;
    btnd = 1'b1;
    tick(); tick();
    btnd = 1'b0;
    repeat (10) begin
      tick();
      if (busy) busy_seen = 1'b1;
    end
    check_eq("t3_busy_seen", 32'(busy_seen), 32'd1);
    check_eq("t3_busy_end",  32'(busy),      32'd0);
    check_eq("t3_pulses",    32'(pulse_cnt - p0), 32'd0);
    check_eq("t3_press_cnt", 32'(press_cnt), 32'd1);

    // T4: bounce on release gives one strobe; busy drops after the release window.
    p0 = pulse_cnt;
    btnd = 1'b1; repeat (10) tick();
    btnd = 1'b0; tick();
    btnd = 1'b1; tick();
    check_eq("t4_busy_bounce", 32'(busy), 32'd1);
    btnd = 1'b0; tick();
    btnd = 1'b1; tick();
    btnd = 1'b0;
    repeat (5) tick();
    check_eq("t4_busy_rel5", 32'(busy), 32'd1);
    tick();
    check_eq("t4_busy_rel6", 32'(busy), 32'd0);
    repeat (4) tick();
    check_eq("t4_pulses",    32'(pulse_cnt - p0), 32'd1);
    check_eq("t4_press_cnt", 32'(press_cnt), 32'd2);

    // T5: inputs changed during RELEASE do not disturb captured values.
    sw = 16'h0ff0; btnl = 1'b1; btnc = 1'b1; btnr = 1'b0;
    btnd = 1'b1;
    repeat (10) tick();
    check_eq("t5_alu_fire", 32'(alu_op),  32'h6);
    check_eq("t5_opd_fire", 32'(operand), 32'h0ff0);
    sw = 16'hffff; btnc = 1'b0;
    repeat (5) tick();
    check_eq("t5_alu_rel", 32'(alu_op),  32'h6);
    check_eq("t5_opd_rel", 32'(operand), 32'h0ff0);
    btnd = 1'b0;
    repeat (10) tick();
    check_eq("t5_alu_idle", 32'(alu_op),  32'h6);
    check_eq("t5_opd_idle", 32'(operand), 32'h0ff0);
    check_eq("t5_cnt",      32'(press_cnt), 32'd3);
    btnd = 1'b1;
    repeat (7) tick();
    check_eq("t5_acc_next", 32'(acc_en),  32'd1);
    check_eq("t5_alu_next", 32'(alu_op),  32'h4);
    check_eq("t5_opd_next", 32'(operand), 32'hffff);
    btnd = 1'b0;
    repeat (10) tick();

    // T6: 256 presses wrap the 8-bit counter back to zero.
    btnu = 1'b1;
    tick(); tick();
    btnu = 1'b0;
    check_eq("t6_cnt_start", 32'(press_cnt), 32'd0);
    p0 = pulse_cnt;
    for (int i = 1; i <= 256; i++) begin
      btnd = 1'b1; repeat (8) tick();
      btnd = 1'b0; repeat (7) tick();
      if (i == 255) check_eq("t6_cnt_255", 32'(press_cnt), 32'd255);
    end
    check_eq("t6_cnt_wrap", 32'(press_cnt), 32'd0);
    check_eq("t6_pulses",   32'(pulse_cnt - p0), 32'd256);
    check_eq("t6_busy",     32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
